// File: rtl/spelled_digit_translator_pkg.sv
// Shared definitions for the calibration stream stages:
// ASCII constants, spelled-word table and summing-stage state.
package spelled_digit_translator_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'd48;
  localparam logic [7:0] ASCII_NINE = 8'd57;
  localparam logic [7:0] ASCII_NL   = 8'd10;

  localparam int NUM_WORDS = 9;

  typedef struct packed {
    logic [39:0] chars;
    logic [2:0]  len;
    logic [3:0]  value;
  } word_t;

  // Words are right-aligned so the last letter sits in the low byte.
  localparam word_t WORDS [NUM_WORDS] = '{
    '{{16'h0, "one"},   3'd3, 4'd1},
    '{{16'h0, "two"},   3'd3, 4'd2},
    '{"three",          3'd5, 4'd3},
    '{{8'h0, "four"},   3'd4, 4'd4},
    '{{8'h0, "five"},   3'd4, 4'd5},
    '{{16'h0, "six"},   3'd3, 4'd6},
    '{"seven",          3'd5, 4'd7},
    '{"eight",          3'd5, 4'd8},
    '{{8'h0, "nine"},   3'd4, 4'd9}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_LAST
  } state_t;

  function automatic logic [39:0] len_mask(input logic [2:0] len);
    return ~({40{1'b1}} << ({3'd0, len} * 6'd8));
  endfunction

endpackage

// File: rtl/spelled_digit_translator_match.sv
// Combinational spelled-word detector over a 5-byte window
// whose low byte is the byte arriving this cycle.
module spelled_word_match
  import spelled_digit_translator_pkg::*;
(
  input  logic [39:0] window,
  output logic        match,
  output logic [3:0]  value
);

  // Descending scan so the lowest value is the last writer.
  always_comb begin
    match = 1'b0;
    value = 4'd0;
    for (int i = NUM_WORDS - 1; i >= 0; i--) begin
      if ((window & len_mask(WORDS[i].len)) == WORDS[i].chars) begin
        match = 1'b1;
        value = WORDS[i].value;
      end
    end
  end

endmodule

// File: rtl/spelled_digit_translator.sv
// Replaces the last letter of each spelled digit in the
// byte stream with its ASCII digit; one cycle latency.
module spelled_digit_translator
  import spelled_digit_translator_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               input_valid,
  input  logic [7:0]         char_in,
  output logic               out_valid,
  output logic [7:0]         char_out,
  output logic [COUNT_W-1:0] word_count,
  output logic [COUNT_W-1:0] line_count
);

  logic [7:0]  hist [4];
  logic [39:0] window;
  logic        match;
  logic [3:0]  value;

  assign window = {hist[3], hist[2], hist[1], hist[0], char_in};

  spelled_word_match u_match (
    .window (window),
    .match  (match),
    .value  (value)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      char_out   <= 8'h00;
      word_count <= '0;
      line_count <= '0;
      for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
    end else if (input_valid) begin
      out_valid <= 1'b1;
      char_out  <= match ? ASCII_ZERO + {4'd0, value} : char_in;
      if (match) word_count <= word_count + 1'b1;
      if (char_in == ASCII_NL) begin
        line_count <= line_count + 1'b1;
        for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
      end else begin
        hist[0] <= char_in;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        hist[3] <= hist[2];
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spelled_digit_translator.sv
// Bench for spelled_digit_translator: directed scenarios plus
// random streams against a string-suffix reference model.
module tb_spelled_digit_translator;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          input_valid = 1'b0;
  logic [7:0]    char_in = 8'h00;
  logic          out_valid;
  logic [7:0]    char_out;
  logic [CW-1:0] word_count;
  logic [CW-1:0] line_count;

  int vectors = 0;
  int errors = 0;

  // reference model state
  byte unsigned line_q[$];
  logic         m_valid;
  logic [7:0]   m_char;
  int           m_wc;
  int           m_lc;
  string        got;

  string words[9] = '{"one", "two", "three", "four", "five",
                      "six", "seven", "eight", "nine"};

  spelled_digit_translator #(.COUNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_valid (input_valid),
    .char_in     (char_in),
    .out_valid   (out_valid),
    .char_out    (char_out),
    .word_count  (word_count),
    .line_count  (line_count)
  );

  always #5 clk = ~clk;

  function automatic int suffix_word(input byte unsigned q[$]);
    for (int v = 0; v < 9; v++) begin
      int n;
      bit ok;
      n = words[v].len();
      ok = (q.size() >= n);
      for (int k = 0; ok && k < n; k++)
        if (q[q.size() - n + k] != words[v][k]) ok = 0;
      if (ok) return v + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    line_q.delete();
    m_valid = 0;
    m_char = 8'h00;
    m_wc = 0;
    m_lc = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] c);
    int d;
    if (!v) begin
      m_valid = 0;
      return;
    end
    m_valid = 1;
    if (c == 8'd10) begin
      m_char = c;
      m_lc++;
      line_q.delete();
    end else begin
      line_q.push_back(c);
      d = suffix_word(line_q);
      m_char = (d != 0) ? 8'(48 + d) : c;
      if (d != 0) m_wc++;
    end
  endtask

  task automatic check_outputs(input string tag);
    vectors++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL %s out_valid got %b exp %b", tag, out_valid, m_valid);
    end
    vectors++;
    if (char_out !== m_char) begin
      errors++;
      $display("FAIL %s char_out got %h exp %h", tag, char_out, m_char);
    end
    vectors++;
    if (word_count !== CW'(m_wc)) begin
      errors++;
      $display("FAIL %s word_count got %0d exp %0d", tag, word_count,
               m_wc % (1 << CW));
    end
    vectors++;
    if (line_count !== CW'(m_lc)) begin
      errors++;
      $display("FAIL %s line_count got %0d exp %0d", tag, line_count,
               m_lc % (1 << CW));
    end
  endtask

  task automatic step(input bit v, input logic [7:0] c, input string tag);
    @(negedge clk);
    input_valid = v;
    char_in = c;
    @(posedge clk);
    #1;
    model_step(v, c);
    check_outputs(tag);
    if (out_valid) got = $sformatf("%s%c", got, char_out);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], tag);
  endtask

  task automatic check_got(input string exp, input string tag);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s stream got \"%s\" exp \"%s\"", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    input_valid = 1'b1;
    char_in = "e";
    @(posedge clk);
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    input_valid = 1'b0;
  endtask

  task automatic test_basic();
    test_reset();
    got = "";
    send_str("two1nine\n", "two1nine");
    check_got("tw21nin9\n", "two1nine");
    got = "";
    send_str("eightwothree\n", "overlap");
    check_got("eigh8w2thre3\n", "overlap");
    vectors++;
    if (word_count !== CW'(5)) begin
      errors++;
      $display("FAIL overlap_wc got %0d exp 5", word_count);
    end
  endtask

  task automatic test_newline_break();
    test_reset();
    got = "";
    send_str("on\ne\n", "nl_break");
    check_got("on\ne\n", "nl_break");
  endtask

  task automatic test_idle_gap();
    test_reset();
    got = "";
    step(1'b1, "f", "idle");
    step(1'b1, "o", "idle");
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, "idle_gap");
    step(1'b1, "u", "idle");
    step(1'b1, "r", "idle");
    check_got("fou4", "idle");
  endtask

  task automatic test_reset_midword();
    test_reset();
    send_str("sev", "midword");
    test_reset();
    got = "";
    send_str("en\n", "midword");
    check_got("en\n", "midword");
  endtask

  task automatic test_case_and_digits();
    test_reset();
    got = "";
    send_str("ONE on1e six\n", "case");
    check_got("ONE on1e si6\n", "case");
  endtask

  task automatic test_random();
    string alph;
    alph = "onetwhrfuivsxgEN1\n";
    test_reset();
    for (int i = 0; i < 3000; i++) begin
      bit v;
      logic [7:0] c;
      v = ($urandom_range(0, 9) != 0);
      c = alph[$urandom_range(0, alph.len() - 1)];
      step(v, c, "random");
      if ($urandom_range(0, 499) == 0) test_reset();
    end
  endtask

  initial begin
    model_reset();
    got = "";
    test_reset();
    test_basic();
    test_newline_break();
    test_idle_gap();
    test_reset_midword();
    test_case_and_digits();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
